// File: rtl/fsu_add_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fsu_add_gen
//  Purpose  : Fully-streaming unary scaled adder. Popcounts IDIM input
//             bitstreams through a pipelined adder tree, integrates the count
//             into a signed clamped accumulator and emits one bitstream whose
//             rate is the input sum divided by SCAL (unipolar or bipolar).
//  Revision : 1.0  initial release
// ============================================================================
module fsu_add_gen #(
    parameter int IDIM = 320,
    parameter int SCAL = IDIM,
    parameter int MODE = 0,
    parameter int BDEP = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iVld,
    input  logic            iClr,
    input  logic [IDIM-1:0] iBit,
    output logic            oBit,
    output logic            oVld,
    output logic            oSat
);

    // Accumulator width is derived so that acc + inc can never wrap.
    localparam int AWID = $clog2(2*IDIM + 4*SCAL) + 2;
    localparam int PW   = $clog2(IDIM + 1);
    // First tree stage splits the inputs into NG groups; each later stage
    // halves the number of partial sums, leaving one sum after BDEP stages.
    localparam int NG   = (BDEP == 0) ? 1 : (1 << (BDEP - 1));
    localparam int GSZ  = (IDIM + NG - 1) / NG;
    localparam int PADW = NG * GSZ;
    localparam int THR  = (MODE == 0) ? SCAL : 2*SCAL;

    localparam logic signed [AWID-1:0] C_THR = AWID'(THR);
    localparam logic signed [AWID-1:0] C_LO  = AWID'(-THR);
    localparam logic signed [AWID-1:0] C_HI  = AWID'(THR - 1);
    localparam logic signed [AWID-1:0] C_OFS = AWID'(SCAL - IDIM);

    logic [IDIM-1:0] r_bit_q;
    logic            r_vin_q;

    // Input capture stage; a sample presented together with iClr is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_q <= '0;
            r_vin_q <= 1'b0;
        end else begin
            r_bit_q <= iBit;
            r_vin_q <= iVld & ~iClr;
        end
    end

    logic [PADW-1:0] w_bit_pad;
    logic [PW-1:0]   w_grp [NG];

    assign w_bit_pad = PADW'(r_bit_q);

    // Per-group popcount of the captured bits (padding lanes read as zero).
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            w_grp[g] = '0;
            for (int b = 0; b < GSZ; b++) begin
                w_grp[g] = w_grp[g] + PW'(w_bit_pad[g*GSZ + b]);
            end
        end
    end

    logic [PW-1:0] w_pcnt;
    logic          w_pvld;

    generate
        if (BDEP == 0) begin : g_comb
            assign w_pcnt = w_grp[0];
            assign w_pvld = r_vin_q;
        end else begin : g_pipe
            logic [PW-1:0]   r_sum_q [BDEP][NG];
            logic [BDEP-1:0] r_vld_q;

            // Adder-tree registers with a valid bit riding alongside, no stall.
            // Lanes above the live partial-sum count carry don't-care values;
            // only lane 0 of the last stage is consumed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < BDEP; k++) begin
                        for (int i = 0; i < NG; i++) begin
                            r_sum_q[k][i] <= '0;
                        end
                    end
                    r_vld_q <= '0;
                end else begin
                    r_vld_q[0] <= r_vin_q & ~iClr;
                    for (int k = 1; k < BDEP; k++) begin
                        r_vld_q[k] <= r_vld_q[k-1] & ~iClr;
                    end
                    for (int i = 0; i < NG; i++) begin
                        r_sum_q[0][i] <= w_grp[i];
                    end
                    for (int k = 1; k < BDEP; k++) begin
                        for (int i = 0; i < NG/2; i++) begin
                            r_sum_q[k][i] <= r_sum_q[k-1][2*i] + r_sum_q[k-1][2*i+1];
                        end
                        for (int i = NG/2; i < NG; i++) begin
                            r_sum_q[k][i] <= '0;
                        end
                    end
                end
            end

            assign w_pcnt = r_sum_q[BDEP-1][0];
            assign w_pvld = r_vld_q[BDEP-1];
        end
    endgenerate

    logic signed [AWID-1:0] r_acc_q;
    logic signed [AWID-1:0] w_p_s;
    logic signed [AWID-1:0] w_inc;
    logic signed [AWID-1:0] w_acc_new;
    logic signed [AWID-1:0] w_acc_sub;
    logic signed [AWID-1:0] w_acc_d;
    logic                   w_o;
    logic                   w_sat;

    // Integrate the count, emit a bit when the threshold is reached, clamp.
    always_comb begin
        w_p_s = $signed({{(AWID-PW){1'b0}}, w_pcnt});
        if (MODE == 0) begin
            w_inc = w_p_s;
        end else begin
            // Bipolar increment 2p - IDIM + SCAL keeps thr = 2*SCAL centred.
            w_inc = (w_p_s <<< 1) + C_OFS;
        end
        w_acc_new = r_acc_q + w_inc;
        w_o       = (w_acc_new >= C_THR);
        w_acc_sub = w_o ? (w_acc_new - C_THR) : w_acc_new;
        if (w_acc_sub < C_LO) begin
            w_acc_d = C_LO;
        end else if (w_acc_sub > C_HI) begin
            w_acc_d = C_HI;
        end else begin
            w_acc_d = w_acc_sub;
        end
        w_sat = (w_acc_d != w_acc_sub);
    end

    logic r_obit_q;
    logic r_ovld_q;
    logic r_osat_q;

    // Accumulator and registered outputs; clear overrides any update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q  <= '0;
            r_obit_q <= 1'b0;
            r_ovld_q <= 1'b0;
            r_osat_q <= 1'b0;
        end else if (iClr) begin
            r_acc_q  <= '0;
            r_obit_q <= 1'b0;
            r_ovld_q <= 1'b0;
            r_osat_q <= 1'b0;
        end else if (w_pvld) begin
            r_acc_q  <= w_acc_d;
            r_obit_q <= w_o;
            r_ovld_q <= 1'b1;
            r_osat_q <= w_sat;
        end else begin
            r_ovld_q <= 1'b0;
            r_osat_q <= 1'b0;
        end
    end

    assign oBit = r_obit_q;
    assign oVld = r_ovld_q;
    assign oSat = r_osat_q;

endmodule
`default_nettype wire

// File: tb/tb_fsu_add_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsu_add_gen
//  Purpose  : Self-checking bench for fsu_add_gen. Five configurations share
//             one stimulus stream; a time-indexed reference model derives the
//             expected oVld/oBit/oSat of each from the arithmetic rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsu_add_gen;

    localparam int NI   = 5;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        clr;
    logic [7:0]  bit8;
    logic [12:0] bit13;
    logic [NI-1:0] obit;
    logic [NI-1:0] ovld;
    logic [NI-1:0] osat;

    always #5 clk = ~clk;

    fsu_add_gen #(.IDIM(8),  .SCAL(8), .MODE(0), .BDEP(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .iVld(vld), .iClr(clr), .iBit(bit8),
        .oBit(obit[0]), .oVld(ovld[0]), .oSat(osat[0]));
    fsu_add_gen #(.IDIM(8),  .SCAL(8), .MODE(1), .BDEP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .iVld(vld), .iClr(clr), .iBit(bit8),
        .oBit(obit[1]), .oVld(ovld[1]), .oSat(osat[1]));
    fsu_add_gen #(.IDIM(8),  .SCAL(4), .MODE(0), .BDEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .iVld(vld), .iClr(clr), .iBit(bit8),
        .oBit(obit[2]), .oVld(ovld[2]), .oSat(osat[2]));
    fsu_add_gen #(.IDIM(8),  .SCAL(2), .MODE(1), .BDEP(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .iVld(vld), .iClr(clr), .iBit(bit8),
        .oBit(obit[3]), .oVld(ovld[3]), .oSat(osat[3]));
    fsu_add_gen #(.IDIM(13), .SCAL(5), .MODE(1), .BDEP(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .iVld(vld), .iClr(clr), .iBit(bit13),
        .oBit(obit[4]), .oVld(ovld[4]), .oSat(osat[4]));

    function automatic int cfg_idim(input int i);
        return (i == 4) ? 13 : 8;
    endfunction
    function automatic int cfg_scal(input int i);
        case (i)
            0, 1:    return 8;
            2:       return 4;
            3:       return 2;
            default: return 5;
        endcase
    endfunction
    function automatic int cfg_mode(input int i);
        return (i == 1 || i == 3 || i == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_bdep(input int i);
        case (i)
            3:       return 0;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // Reference state and input history indexed by clock-edge number.
    int   m_acc  [NI];
    logic m_obit [NI];
    logic m_ovld [NI];
    logic m_osat [NI];
    bit   h_vld  [HMAX];
    bit   h_clr  [HMAX];
    int   h_p    [NI][HMAX];
    int   kill_e;
    int   edge_n;
    int   n_chk;
    int   n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bits_k(input int k);
        logic [7:0] b;
        b = '0;
        while ($countones(b) < k) b[$urandom_range(7, 0)] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_acc[i]  = 0;
            m_obit[i] = 1'b0;
            m_ovld[i] = 1'b0;
            m_osat[i] = 1'b0;
        end
    endtask

    // A sample taken at edge s updates the output at edge s+BDEP+1 unless a
    // clear lands on any edge in [s, s+BDEP+1] or a reset hit at/after s.
    task automatic model_edge();
        int n;
        n = edge_n;
        h_vld[n] = vld;
        h_clr[n] = clr;
        for (int i = 0; i < NI; i++) h_p[i][n] = (i == 4) ? $countones(bit13) : $countones(bit8);
        if (!rst_n) begin
            kill_e = n;
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                int  s;
                bit  upd;
                if (clr) begin
                    m_acc[i] = 0; m_obit[i] = 1'b0; m_ovld[i] = 1'b0; m_osat[i] = 1'b0;
                    continue;
                end
                s   = n - (cfg_bdep(i) + 1);
                upd = (s >= 0) && (s > kill_e) && h_vld[s];
                if (upd) begin
                    for (int j = s; j < n; j++) if (h_clr[j]) upd = 1'b0;
                end
                if (upd) begin
                    int thr, inc, an, as_v, cl;
                    bit o;
                    thr  = (cfg_mode(i) == 0) ? cfg_scal(i) : 2*cfg_scal(i);
                    inc  = (cfg_mode(i) == 0) ? h_p[i][s] : 2*h_p[i][s] - cfg_idim(i) + cfg_scal(i);
                    an   = m_acc[i] + inc;
                    o    = (an >= thr);
                    as_v = o ? an - thr : an;
                    cl   = (as_v < -thr) ? -thr : ((as_v > thr - 1) ? thr - 1 : as_v);
                    m_acc[i]  = cl;
                    m_obit[i] = o;
                    m_ovld[i] = 1'b1;
                    m_osat[i] = (cl != as_v);
                end else begin
                    m_ovld[i] = 1'b0;
                    m_osat[i] = 1'b0;
                end
            end
        end
        edge_n++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d edge%0d vld/bit/sat", i, edge_n - 1),
                  {29'd0, ovld[i], obit[i], osat[i]},
                  {29'd0, m_ovld[i], m_obit[i], m_osat[i]});
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check
    // at the next falling edge.
    task automatic step(input bit v, input bit c, input int p8);
        vld   = v;
        clr   = c;
        bit8  = bits_k(p8);
        bit13 = 13'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_const(input int p8, input int ncyc);
        step(1'b0, 1'b1, 0);
        for (int k = 0; k < ncyc; k++) step(1'b1, 1'b0, p8);
    endtask

    task automatic run_random(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            step(($urandom % 4) != 0, ($urandom % 40) == 0, int'($urandom_range(8, 0)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_err  = 0;
        edge_n = 0;
        kill_e = -1;
        model_reset();
        rst_n = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        bit8  = '0;
        bit13 = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {17'd0, ovld, obit, osat}, 32'd0);
        rst_n = 1'b1;

        // Constant-rate streams: full, half, empty and 6/8 rates.
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8);
        run_const(4, 16);
        run_const(0, 12);
        run_const(6, 16);
        run_const(8, 10);

        // Valid gaps 1,0,1,1,0 at p=4 then drain.
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 4);
        step(1'b1, 1'b0, 4);
        step(1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 4);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0);

        // Clear with two samples in flight, then restart at p=4.
        step(1'b1, 1'b0, 8);
        step(1'b1, 1'b0, 8);
        step(1'b1, 1'b1, 8);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4);

        run_random(400);

        // Asynchronous reset between edges mid-stream.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {17'd0, ovld, obit, osat}, 32'd0);
        kill_e = edge_n - 1;
        model_reset();
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 8);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4);
        run_random(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
